sig_pulse_generator: RTL
========================

// Module: sig_pulse_generator
// PURPOSE
//  Transmit side of the sig pulse-count interface. Emits a programmed burst of
//  N single-cycle sig pulses, spaced by a fixed low gap, for a sig_on_counter
//  style receiver that counts them. Sits between the control FSM and the
//  counter's sig input; reports busy/done back to the controller.
// PARAMETERS
//  MAX_COUNT   10  receiver terminal count; largest legal burst is MAX_COUNT+1
//  GAP_CYCLES  1   sig-low cycles between consecutive pulses (>=1)
//  CNT_W       5   width of count_in/pulses_sent; must hold MAX_COUNT+1
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      asynchronous, active-low reset
//  start        in   1      request burst; sampled only in IDLE
//  count_in     in   CNT_W  pulses to send; latched on accepted start
//  sig          out  1      registered pulse output to receiver
//  busy         out  1      high from accepted start until DONE exits
//  done         out  1      one-cycle strobe after last pulse/gap
//  pulses_sent  out  CNT_W  pulses emitted in current/last burst
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, sig=0, busy=0, done=0, pulses_sent=0.
//  FSM: IDLE -> PULSE -> GAP -> (PULSE | DONE) -> IDLE.
//   IDLE: start=1 latches N=count_in, clears pulses_sent, busy=1 next cycle.
//         N=0 -> DONE directly (no pulse). Else -> PULSE.
//   PULSE: sig=1 exactly one cycle; pulses_sent increments same edge.
//   GAP: sig=0 for GAP_CYCLES; then PULSE if pulses_sent<N, else DONE.
//   DONE: done=1 one cycle, busy=0 on the following cycle, -> IDLE.
//  Latency: start at edge t -> sig high in cycle t+1. Burst length
//   N*(1+GAP_CYCLES) cycles, then 1 DONE cycle.
//  count_in > MAX_COUNT+1 clamps to MAX_COUNT+1 (never overruns receiver).
//  start while busy: ignored, no queuing. start and DONE same cycle: ignored;
//   a new start is accepted only in IDLE.
//  pulses_sent holds its final value in IDLE until next accepted start.
//  sig is glitch-free: driven only from a flop, never decoded combinationally.
//  Reset mid-burst: sig drops immediately (async); no done strobe issued.
// CONFIGURATION
//  SIG_GEN_ABORT_EN defined: adds input abort (1 bit). abort=1 in PULSE/GAP
//   -> sig=0 next edge, state -> DONE, done strobes, pulses_sent keeps count
//   reached. abort in IDLE/DONE ignored. abort beats pulse increment when both
//   occur in the same cycle (the aborted PULSE cycle still counts if sig was
//   already high that cycle).
//  Not defined: no abort port; bursts always run to completion.
// STRUCTURE
//  Package sig_pkg: typedef enum logic [1:0] {IDLE,PULSE,GAP,DONE} sig_gen_state_t;
//   localparam CNT_W default, clamp helper function sat_count().
//  Sub-module gap_timer: load/run down-counter, asserts expired after
//   GAP_CYCLES; instantiated once. Top holds FSM, N register, pulses_sent.
// TESTING
//  count_in=3, GAP_CYCLES=1: start@t -> sig high t+1,t+3,t+5; done@t+7; pulses_sent=3.
//  count_in=0: start -> no sig, done one cycle later, pulses_sent=0, busy 1 cycle.
//  count_in=31, MAX_COUNT=10: exactly 11 pulses; paired sig_on_counter asserts max_reached once.
//  start held high through a burst of 4: exactly 4 pulses, second burst starts
//   only after return to IDLE.
//  rst low after 2nd pulse of 5: sig/busy/done=0 at once; after release, IDLE, no done.
//  SIG_GEN_ABORT_EN: count_in=6, abort after 2nd pulse -> no 3rd pulse, done strobe, pulses_sent=2.

Source files
------------

// File: rtl/sig_pulse_generator_pkg.sv
// Shared types and helpers for the sig pulse generator.
// Abort support is selected at build time with SIG_GEN_ABORT_EN.
package sig_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} sig_gen_state_t;

  localparam int CNT_W_DEFAULT = 5;

  // Saturate a requested burst length to the receiver's largest legal burst.
  function automatic int unsigned sat_count(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sig_pulse_generator_if.sv
// Controller-facing bundle of the sig pulse generator.
// With SIG_GEN_ABORT_EN defined the bundle carries an abort request.
interface sig_pulse_generator_if #(parameter int CNT_W = sig_pkg::CNT_W_DEFAULT);
  logic             start;
  logic [CNT_W-1:0] count_in;
  logic             sig;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_sent;
`ifdef SIG_GEN_ABORT_EN
  logic             abort;
`endif

  modport master (
    output start, count_in,
`ifdef SIG_GEN_ABORT_EN
    output abort,
`endif
    input  sig, busy, done, pulses_sent
  );

  modport slave (
    input  start, count_in,
`ifdef SIG_GEN_ABORT_EN
    input  abort,
`endif
    output sig, busy, done, pulses_sent
  );
endinterface

// File: rtl/sig_pulse_generator_gap_timer.sv
// Low-gap timer: reloads while a pulse is out, then counts down during the gap.
module gap_timer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);
  localparam int TW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(GAP_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Terminal count is reached in the last gap cycle.
  assign expired = run && (cnt_q == '0);
endmodule

// File: rtl/sig_pulse_generator.sv
// Emits a burst of single-cycle sig pulses for a pulse-counting receiver.
// Optional abort input when SIG_GEN_ABORT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for start, pulses_sent holds last burst result
//   PULSE | sig high for this single cycle
//   GAP   | sig low for GAP_CYCLES
//   DONE  | one-cycle done strobe, busy still high
module sig_pulse_generator
  import sig_pkg::*;
#(
  parameter int MAX_COUNT  = 10,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  sig_pulse_generator_if.slave  bus
);
  sig_gen_state_t   state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] req_n;
  logic             sig_q, busy_q, done_q;
  logic             abort_req;
  logic             timer_load, timer_run, gap_expired;

`ifdef SIG_GEN_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign req_n = CNT_W'(sat_count(32'(bus.count_in), 32'(MAX_COUNT + 1)));

  assign timer_load = (state_q == PULSE);
  assign timer_run  = (state_q == GAP);

  gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .run     (timer_run),
    .expired (gap_expired)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = req_n;
          sent_d  = '0;
          state_d = (req_n == '0) ? DONE : PULSE;
        end
      end
      PULSE:   state_d = abort_req ? DONE : GAP;
      GAP: begin
        if (abort_req)        state_d = DONE;
        else if (gap_expired) state_d = (sent_q < n_q) ? PULSE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Count each pulse on the same edge that raises sig.
    if (state_d == PULSE) sent_d = sent_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      sent_q  <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
      sig_q   <= (state_d == PULSE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.sig         = sig_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;
endmodule
